systolic_seq_ctrl: RTL and testbench
====================================

# systolic_seq_ctrl

Sequencer for the N×N output-stationary systolic array. On `start` it clears the PE accumulators and issues K operand-buffer reads. It generates the per-row and per-column skewed feed enables and counts the array drain. It then raises per-row `valid_out` and `busy`/`done` status to the top-level wrapper, and owns the `clear_all` abort/clear path.

## Interface
- `N`, 4, array dimension (rows = cols = N), 2..16
- `K_MAX`, 256, maximum inner-product length
- `KW`, $clog2(K_MAX+1), width of `k_len`
- `AW`, $clog2(K_MAX), operand-buffer address width
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  reset, synchronous, active-low (0 = reset)
- `start`  in  1  run request, sampled in IDLE only
- `clear_all`  in  1  clear results / abort run
- `k_len`  in  KW  inner-product length, latched when `start` is accepted; values > K_MAX are saturated to K_MAX
- `rd_en`  out  1  operand-buffer read strobe (A and B buffers, shared)
- `rd_addr`  out  AW  operand-buffer read address
- `row_en`  out  N  A-operand valid into row i, skewed
- `col_en`  out  N  B-operand valid into column j, skewed
- `acc_clr`  out  1  one-cycle synchronous clear of all PE accumulators
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle run-complete pulse
- `valid_out`  out  N  row r results final; sticky

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - `start`=1 and `clear_all`=0 → CLEAR; latch `k_len`.
- CLEAR (1 cycle):
  - `acc_clr`=1, `valid_out` cleared, counter reset.
  - Next state is FEED, or DRAIN if latched K=0.
- FEED (K cycles, cycle index T=0..K-1):
  - `rd_en`=1, `rd_addr`=T.
  - Then → DRAIN.
- DRAIN (2N cycles, T=K..K+2N-1):
  - `rd_en`=0; skew lines flush.
  - Then → DONE.
- DONE (T=K+2N, 1 cycle):
  - `done`=1.
  - Then → IDLE.
- Skew: buffer read latency is 1 cycle.
  - `row_en[i]` = `rd_en` delayed 1+i cycles.
  - `col_en[j]` = `rd_en` delayed 1+j cycles.
- `valid_out[r]` sets at T=K+N+r and holds until the next CLEAR, a `clear_all`, or reset.
- `clear_all`:
  - In IDLE: `acc_clr`=1 for one cycle and `valid_out` cleared.
  - In any other state: abort. Next cycle is IDLE, `acc_clr`=1, skew lines and `valid_out` zeroed, no `done`.
- `start` while not IDLE: ignored, not queued.
- `start` and `clear_all` in the same cycle: `clear_all` wins, `start` is dropped.
- Counter: KW+1 bits wide so that K+2N never wraps.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE and every output is 0 (`rd_en`, `rd_addr`, `row_en`, `col_en`, `acc_clr`, `busy`, `done`, `valid_out`). Reset mid-run has the same effect; no `done` is produced.
- All outputs are registered.
- `busy`:
  - Rises in the cycle after `start` is accepted (the CLEAR cycle).
  - Stays 1 through DONE.
  - Falls in the first IDLE cycle.
- Total latency from the `start` edge to the `done` pulse is K+2N+1 cycles.
- The `busy` high time is K+2N+2 cycles.
- The last PE(N-1,N-1) MAC occurs at T=K+2N-2, which is before `valid_out[N-1]` at T=K+2N-1.
- Back-to-back runs: `start` may be asserted in the first IDLE cycle after DONE.

## Structure
- Package `systolic_pkg`:
  - `seq_state_t` enum (IDLE, CLEAR, FEED, DRAIN, DONE).
  - Default N and K_MAX localparams, shared with the array.
- Sub-module `systolic_skew`:
  - Parameterised N-tap shift register with synchronous clear.
  - Output tap i = input delayed 1+i cycles.
  - Instantiated twice, once for rows and once for columns.

## Test plan
- Reset: hold `rst`=0 for 5 cycles with `start`=1 → all outputs 0 and no state change; after release, IDLE.
- Nominal run, N=4, K=4, `start` pulse:
  - `busy` high for 14 cycles.
  - `rd_addr` sequence 0,1,2,3.
  - `row_en[3]`/`col_en[3]` high at T=4..7.
  - `valid_out` goes 0001→0011→0111→1111 at T=8..11.
  - `done` at T=12.
- Abort: `clear_all` at T=5 of a K=4 run → IDLE next cycle, `acc_clr`=1, `valid_out`=0000, no `done`, `busy`=0.
- Collisions:
  - `start` during busy → ignored, no change to that run's timing.
  - `start`+`clear_all` together in IDLE → no run, `acc_clr` pulse only.
- Edge lengths:
  - K=0 → no `rd_en`, `done` 9 cycles after `start`, `valid_out`=1111.
  - K=K_MAX=256 → `rd_addr` reaches 255 without wrap, `done` at T=264.
- Back-to-back: second `start` in the first IDLE cycle after `done` → CLEAR cycle zeroes `valid_out`, then a full run with identical timing.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic array and its sequencer.
package systolic_pkg;

    // Default array geometry, shared by the PE array and the sequencer
    localparam int DEF_N     = 4;
    localparam int DEF_K_MAX = 256;

    // Sequencer state width and encoding
    localparam int SEQ_SW = 3;

    typedef enum logic [SEQ_SW-1:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_CLEAR = 3'd1,
        SEQ_FEED  = 3'd2,
        SEQ_DRAIN = 3'd3,
        SEQ_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/systolic_skew.sv
// N-tap skew shift register: tap i carries the input delayed by 1+i cycles.
// Used once for the A-operand rows and once for the B-operand columns.
module systolic_skew
    import systolic_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_in,
    output logic [N-1:0] o_tap
);

    logic [N-1:0] r_tap;

    // Shift the strobe one tap per cycle; reset and clear flush every tap at once
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_clr) begin
            r_tap <= '0;
        end else begin
            r_tap <= {r_tap[N-2:0], i_in};
        end
    end

    assign o_tap = r_tap;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Run sequencer for the NxN output-stationary systolic array.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; clear_all here only pulses acc_clr
//   CLEAR | one cycle: acc_clr, valid_out cleared, counter to 0
//   FEED  | K cycles: operand reads, rd_addr = T
//   DRAIN | 2N cycles: skew lines flush, valid_out fills row by row
//   DONE  | one cycle: done pulse, then back to IDLE
//
// r_cnt holds T, the cycle index from the first FEED cycle; it is one
// bit wider than k_len so K+2N never wraps. Every output is a register
// loaded from the next-state decode, so outputs line up with the state
// they describe.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int K_MAX = DEF_K_MAX,
    parameter int KW    = $clog2(K_MAX + 1),
    parameter int AW    = $clog2(K_MAX)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_clear_all,
    input  logic [KW-1:0] i_k_len,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    output logic [N-1:0]  o_row_en,
    output logic [N-1:0]  o_col_en,
    output logic          o_acc_clr,
    output logic          o_busy,
    output logic          o_done,
    output logic [N-1:0]  o_valid_out
);

    localparam int CW = KW + 1;

    localparam logic [SEQ_SW-1:0] S_IDLE  = SEQ_IDLE;
    localparam logic [SEQ_SW-1:0] S_CLEAR = SEQ_CLEAR;
    localparam logic [SEQ_SW-1:0] S_FEED  = SEQ_FEED;
    localparam logic [SEQ_SW-1:0] S_DRAIN = SEQ_DRAIN;
    localparam logic [SEQ_SW-1:0] S_DONE  = SEQ_DONE;

    logic [SEQ_SW-1:0] r_state;
    logic [SEQ_SW-1:0] w_nxt_state;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_nxt_cnt;
    logic [KW-1:0]     r_k;
    logic [KW-1:0]     w_nxt_k;
    logic [KW-1:0]     w_k_sat;
    logic [CW-1:0]     w_k_ext;
    logic [CW-1:0]     w_feed_last;
    logic [CW-1:0]     w_drain_last;
    logic              w_nxt_acc_clr;
    logic              w_clr_valid;
    logic [N-1:0]      w_valid_set;

    logic              r_rd_en;
    logic [AW-1:0]     r_rd_addr;
    logic              r_acc_clr;
    logic              r_busy;
    logic              r_done;
    logic [N-1:0]      r_valid;

    // Saturate the requested length and derive the terminal counts for FEED and DRAIN
    always_comb begin
        w_k_sat      = (i_k_len > KW'(K_MAX)) ? KW'(K_MAX) : i_k_len;
        w_k_ext      = {1'b0, r_k};
        w_feed_last  = w_k_ext - CW'(1);
        w_drain_last = w_k_ext + CW'(2 * N - 1);
    end

    // Next-state decode; clear_all overrides everything, including a start in the same cycle
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_k       = r_k;
        w_nxt_acc_clr = 1'b0;
        if (i_clear_all) begin
            w_nxt_state   = S_IDLE;
            w_nxt_cnt     = '0;
            w_nxt_acc_clr = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_nxt_state = S_CLEAR;
                        w_nxt_cnt   = '0;
                        w_nxt_k     = w_k_sat;
                    end
                end
                S_CLEAR: begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = (r_k == '0) ? S_DRAIN : S_FEED;
                end
                S_FEED: begin
                    w_nxt_cnt = r_cnt + CW'(1);
                    if (r_cnt == w_feed_last) begin
                        w_nxt_state = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    w_nxt_cnt = r_cnt + CW'(1);
                    if (r_cnt == w_drain_last) begin
                        w_nxt_state = S_DONE;
                    end
                end
                S_DONE: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                end
            endcase
            if (w_nxt_state == S_CLEAR) begin
                w_nxt_acc_clr = 1'b1;
            end
        end
    end

    // Row r's results are final at T = K+N+r, which always falls inside DRAIN
    always_comb begin
        w_clr_valid = i_clear_all || (w_nxt_state == S_CLEAR);
        w_valid_set = '0;
        for (int r = 0; r < N; r++) begin
            w_valid_set[r] = (w_nxt_state == S_DRAIN) &&
                             (w_nxt_cnt == w_k_ext + CW'(N + r));
        end
    end

    // State, counter and all registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_k       <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_acc_clr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_k       <= w_nxt_k;
            r_rd_en   <= (w_nxt_state == S_FEED);
            r_rd_addr <= (w_nxt_state == S_FEED) ? w_nxt_cnt[AW-1:0] : '0;
            r_acc_clr <= w_nxt_acc_clr;
            r_busy    <= (w_nxt_state != S_IDLE);
            r_done    <= (w_nxt_state == S_DONE);
            if (w_clr_valid) begin
                r_valid <= '0;
            end else begin
                r_valid <= r_valid | w_valid_set;
            end
        end
    end

    // Buffer read latency is one cycle, so tap 0 of each skew line sits one cycle behind rd_en
    systolic_skew #(.N(N)) u_row_skew (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clear_all),
        .i_in  (r_rd_en),
        .o_tap (o_row_en)
    );

    systolic_skew #(.N(N)) u_col_skew (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clear_all),
        .i_in  (r_rd_en),
        .o_tap (o_col_en)
    );

    assign o_rd_en     = r_rd_en;
    assign o_rd_addr   = r_rd_addr;
    assign o_acc_clr   = r_acc_clr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_valid_out = r_valid;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: directed runs plus random start/clear/reset
// traffic, compared each cycle against a timeline model of a run.
module tb_systolic_seq_ctrl;

    localparam int N     = 4;
    localparam int K_MAX = 256;
    localparam int KW    = 9;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          clear_all = 1'b0;
    logic [KW-1:0] k_len = '0;

    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [N-1:0]  o_row_en;
    logic [N-1:0]  o_col_en;
    logic          o_acc_clr;
    logic          o_busy;
    logic          o_done;
    logic [N-1:0]  o_valid_out;

    systolic_seq_ctrl #(.N(N), .K_MAX(K_MAX)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_clear_all (clear_all),
        .i_k_len     (k_len),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .o_row_en    (o_row_en),
        .o_col_en    (o_col_en),
        .o_acc_clr   (o_acc_clr),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_valid_out (o_valid_out)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a run is described only by the edge it was accepted on
    // and its length; every output follows from the offset to that edge.
    int           edge_cnt = 0;
    bit           m_active = 1'b0;
    int           m_st     = 0;
    int           m_k      = 0;
    logic [N-1:0] m_vhold  = '0;
    bit           m_acc    = 1'b0;
    bit           m_rst    = 1'b0;

    int busy_cnt  = 0;
    int done_edge = -1;
    int done_cnt  = 0;
    int addr_max  = -1;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    function automatic int sat_k(input int k);
        return (k > K_MAX) ? K_MAX : k;
    endfunction

    task automatic model_edge();
        edge_cnt++;
        m_acc = 1'b0;
        m_rst = 1'b0;
        if (!rst) begin
            m_active = 1'b0;
            m_vhold  = '0;
            m_rst    = 1'b1;
        end else if (clear_all) begin
            m_active = 1'b0;
            m_vhold  = '0;
            m_acc    = 1'b1;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_st     = edge_cnt;
                m_k      = sat_k(int'(k_len));
            end
        end else if (edge_cnt - m_st == m_k + 2 * N + 2) begin
            m_active = 1'b0;
            m_vhold  = '1;
        end
    endtask

    task automatic check_outputs();
        int           m;
        int           t;
        logic [N-1:0] e_skew;
        logic [N-1:0] e_valid;
        bit           e_busy;
        bit           e_done;
        bit           e_rd;
        bit           e_clr;
        int           e_addr;
        e_skew  = '0;
        e_valid = m_vhold;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_rd    = 1'b0;
        e_clr   = m_acc;
        e_addr  = 0;
        if (m_active) begin
            m      = edge_cnt - m_st;
            t      = m - 1;
            e_busy = 1'b1;
            e_clr  = (m == 0);
            e_rd   = (t >= 0) && (t < m_k);
            e_addr = t;
            e_done = (t == m_k + 2 * N);
            for (int i = 0; i < N; i++) begin
                e_skew[i]  = (t - 1 - i >= 0) && (t - 1 - i < m_k);
                e_valid[i] = (t >= m_k + N + i);
            end
        end
        chk_eq("busy",      int'(o_busy),      int'(e_busy));
        chk_eq("done",      int'(o_done),      int'(e_done));
        chk_eq("rd_en",     int'(o_rd_en),     int'(e_rd));
        chk_eq("acc_clr",   int'(o_acc_clr),   int'(e_clr));
        chk_eq("row_en",    int'(o_row_en),    int'(e_skew));
        chk_eq("col_en",    int'(o_col_en),    int'(e_skew));
        chk_eq("valid_out", int'(o_valid_out), int'(e_valid));
        if (e_rd || m_rst) begin
            chk_eq("rd_addr", int'(o_rd_addr), m_rst ? 0 : e_addr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (o_busy) busy_cnt++;
        if (o_done) begin
            done_edge = edge_cnt;
            done_cnt++;
        end
        if (o_rd_en && int'(o_rd_addr) > addr_max) addr_max = int'(o_rd_addr);
    endtask

    task automatic run_one(input string tag, input int k_in, input int k_eff);
        int st;
        k_len     = KW'(k_in);
        start     = 1'b1;
        busy_cnt  = 0;
        done_edge = -1;
        addr_max  = -1;
        step();
        st    = edge_cnt;
        start = 1'b0;
        repeat (k_eff + 2 * N + 4) step();
        chk_eq({tag, "_busy_len"}, busy_cnt, k_eff + 2 * N + 2);
        chk_eq({tag, "_done_lat"}, done_edge - st, k_eff + 2 * N + 1);
        chk_eq({tag, "_addr_max"}, addr_max, k_eff - 1);
    endtask

    initial begin
        int st;

        // reset held with start asserted
        rst   = 1'b0;
        start = 1'b1;
        k_len = KW'(4);
        repeat (5) step();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) step();

        // nominal K=4 run
        run_one("nom", 4, 4);

        // abort with clear_all during T=5
        k_len = KW'(4);
        start = 1'b1;
        done_cnt = 0;
        step();
        start = 1'b0;
        repeat (6) step();
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
        repeat (4) step();
        chk_eq("abort_no_done", done_cnt, 0);

        // start while busy is ignored
        k_len     = KW'(4);
        start     = 1'b1;
        done_edge = -1;
        step();
        st    = edge_cnt;
        start = 1'b0;
        repeat (3) step();
        start = 1'b1;
        k_len = KW'(9);
        step();
        start = 1'b0;
        repeat (12) step();
        chk_eq("start_busy_done_lat", done_edge - st, 4 + 2 * N + 1);

        // start together with clear_all in IDLE
        start     = 1'b1;
        clear_all = 1'b1;
        busy_cnt  = 0;
        step();
        start     = 1'b0;
        clear_all = 1'b0;
        repeat (3) step();
        chk_eq("start_clr_no_run", busy_cnt, 0);

        // length edges
        run_one("k0", 0, 0);
        run_one("kmax", K_MAX, K_MAX);
        run_one("ksat", 300, K_MAX);

        // back-to-back: start held so the second run is taken in the first IDLE cycle
        k_len    = KW'(4);
        start    = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        repeat (2 * (4 + 2 * N + 2) + 1) step();
        start = 1'b0;
        repeat (5) step();
        chk_eq("b2b_done_cnt", done_cnt, 2);
        chk_eq("b2b_busy_len", busy_cnt, 2 * (4 + 2 * N + 2));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 149) != 0);
            start     = ($urandom_range(0, 3) == 0);
            clear_all = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) begin
                k_len = KW'($urandom_range(0, 511));
            end else begin
                k_len = KW'($urandom_range(0, 6));
            end
            step();
        end
        rst       = 1'b1;
        start     = 1'b0;
        clear_all = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
